alu_ctrl_seq: RTL and testbench

//  Registered, parametrised ALU-control decoder with a valid/ready handshake on both sides.

---
 rtl/alu_ctrl_seq.sv | 114 +++++++++++
 tb/tb_alu_ctrl_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU-control decoder with valid/ready handshake and multi-cycle sequencing
module alu_ctrl_seq #(
  parameter int OP_W      = 4,
  parameter int FUNCT_W   = 6,
  parameter int CTRL_W    = 4,
  parameter int MC_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               alu_op,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               illegal,
  output logic               busy
);

  localparam int CNT_W = $clog2(MC_CYCLES);

  typedef enum logic {S_IDLE, S_MULTI} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                out_valid_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic                illegal_q;
  logic                busy_q;

  logic [CTRL_W-1:0]   ctrl_d;
  logic                illegal_d;
  logic                multi_d;
  logic                accept;

  always_comb begin
    ctrl_d    = '0;
    illegal_d = 1'b0;
    multi_d   = 1'b0;
    if (alu_op) begin
      if (op == OP_W'(15)) begin
        if (funct == FUNCT_W'(28)) begin
          ctrl_d  = CTRL_W'(2);
          multi_d = 1'b1;
        end else if (funct != FUNCT_W'(0)) begin
          illegal_d = 1'b1;
        end
      end else if (op == OP_W'(6)) begin
        ctrl_d = CTRL_W'(1);
      end else if (op != OP_W'(4)) begin
        illegal_d = 1'b1;
      end
    end
  end

  // One-entry output register: a new op may enter only once the current result leaves.
  assign in_ready  = !flush && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign ctrl      = ctrl_q;
  assign illegal   = illegal_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (multi_d) begin
              state_q     <= S_MULTI;
              cnt_q       <= CNT_W'(MC_CYCLES - 1);
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              out_valid_q <= 1'b1;
              ctrl_q      <= ctrl_d;
              illegal_q   <= illegal_d;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_MULTI: begin
          if (cnt_q == '0) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            ctrl_q      <= CTRL_W'(2);
            illegal_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed self-checking bench for alu_ctrl_seq (MC_CYCLES 4 and 2)
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       alu_op;
  logic [3:0] op;
  logic [5:0] funct;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, illegal_a, busy_a;
  logic [3:0] ctrl_a;
  logic       in_ready_b, out_valid_b, illegal_b, busy_b;
  logic [3:0] ctrl_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.OP_W(4), .FUNCT_W(6), .CTRL_W(4), .MC_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .alu_op(alu_op), .op(op), .funct(funct), .out_valid(out_valid_a), .out_ready(out_ready),
    .ctrl(ctrl_a), .illegal(illegal_a), .busy(busy_a)
  );

  alu_ctrl_seq #(.OP_W(4), .FUNCT_W(6), .CTRL_W(4), .MC_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .alu_op(alu_op), .op(op), .funct(funct), .out_valid(out_valid_b), .out_ready(out_ready),
    .ctrl(ctrl_b), .illegal(illegal_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic a, input logic [3:0] o, input logic [5:0] f);
    in_valid = 1'b1;
    alu_op   = a;
    op       = o;
    funct    = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_op = 1'b1; op = '0; funct = '0;
    out_ready = 1'b1;
    #3;
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", out_valid_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy_a); end
    vectors++; if (in_ready_a !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b exp 1", in_ready_a); end
    vectors++; if (ctrl_a !== 4'b0000 || illegal_a !== 1'b0) begin miscompares++; $display("FAIL rst_ctrl got %b/%b exp 0000/0", ctrl_a, illegal_a); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin miscompares++; $display("FAIL post_rst got in_ready=%b out_valid=%b exp 1/0", in_ready_a, out_valid_a); end
  endtask

  task automatic test_mid_multi_reset();
    present(1'b1, 4'd15, 6'd28);
    tick();
    in_valid = 1'b0;
    tick();
    vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL mr_busy_before got %b exp 1", busy_a); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL mr_out_valid got %b exp 0", out_valid_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL mr_busy got %b exp 0", busy_a); end
    vectors++; if (in_ready_a !== 1'b1) begin miscompares++; $display("FAIL mr_in_ready got %b exp 1", in_ready_a); end
    #1 rst_n = 1'b1;
    present(1'b1, 4'd4, 6'd0);
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid_a !== 1'b1 || ctrl_a !== 4'b0000 || illegal_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++; $display("FAIL mr_first_op got v=%b c=%b i=%b b=%b exp 1/0000/0/0", out_valid_a, ctrl_a, illegal_a, busy_a); end
    tick();
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL mr_drain got %b exp 0", out_valid_a); end
  endtask

  task automatic test_single();
    logic [3:0] ops [3];
    logic [3:0] exp_ctrl [3];
    ops[0] = 4'd4;  exp_ctrl[0] = 4'b0000;
    ops[1] = 4'd6;  exp_ctrl[1] = 4'b0001;
    ops[2] = 4'd15; exp_ctrl[2] = 4'b0000;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      present(1'b1, ops[k], 6'd0);
      #1;
      vectors++; if (in_ready_a !== 1'b1) begin miscompares++; $display("FAIL sc_in_ready k=%0d got %b exp 1", k, in_ready_a); end
      tick();
      vectors++; if (out_valid_a !== 1'b1 || ctrl_a !== exp_ctrl[k] || illegal_a !== 1'b0) begin
        miscompares++; $display("FAIL sc_out k=%0d got v=%b c=%b i=%b exp 1/%b/0", k, out_valid_a, ctrl_a, illegal_a, exp_ctrl[k]); end
    end
    in_valid = 1'b0;
    tick();
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL sc_drain got %b exp 0", out_valid_a); end
  endtask

  task automatic test_multi();
    out_ready = 1'b1;
    present(1'b1, 4'd15, 6'd28);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (busy_a !== 1'b1 || in_ready_a !== 1'b0 || out_valid_a !== 1'b0) begin
        miscompares++; $display("FAIL mc4_wait t+%0d got b=%b r=%b v=%b exp 1/0/0", k, busy_a, in_ready_a, out_valid_a); end
      if (k < 2) begin
        vectors++; if (busy_b !== 1'b1 || out_valid_b !== 1'b0) begin
          miscompares++; $display("FAIL mc2_wait t+%0d got b=%b v=%b exp 1/0", k, busy_b, out_valid_b); end
      end
      if (k == 2) begin
        vectors++; if (out_valid_b !== 1'b1 || ctrl_b !== 4'b0010 || busy_b !== 1'b0) begin
          miscompares++; $display("FAIL mc2_done got v=%b c=%b b=%b exp 1/0010/0", out_valid_b, ctrl_b, busy_b); end
      end
      tick();
    end
    vectors++; if (out_valid_a !== 1'b1 || ctrl_a !== 4'b0010 || illegal_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++; $display("FAIL mc4_done got v=%b c=%b i=%b b=%b exp 1/0010/0/0", out_valid_a, ctrl_a, illegal_a, busy_a); end
    tick();
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL mc4_drain got %b exp 0", out_valid_a); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    present(1'b1, 4'd6, 6'd0);
    tick();
    present(1'b1, 4'd4, 6'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready k=%0d got %b exp 0", k, in_ready_a); end
      tick();
      vectors++; if (out_valid_a !== 1'b1 || ctrl_a !== 4'b0001) begin
        miscompares++; $display("FAIL bp_hold k=%0d got v=%b c=%b exp 1/0001", k, out_valid_a, ctrl_a); end
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready_a !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b exp 1", in_ready_a); end
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid_a !== 1'b1 || ctrl_a !== 4'b0000) begin
      miscompares++; $display("FAIL bp_replace got v=%b c=%b exp 1/0000", out_valid_a, ctrl_a); end
    tick();
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b exp 0", out_valid_a); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    present(1'b1, 4'd6, 6'd0);
    tick();
    present(1'b1, 4'd3, 6'd0);
    tick();
    vectors++; if (out_valid_a !== 1'b1 || ctrl_a !== 4'b0000 || illegal_a !== 1'b1) begin
      miscompares++; $display("FAIL il_op3 got v=%b c=%b i=%b exp 1/0000/1", out_valid_a, ctrl_a, illegal_a); end
    present(1'b1, 4'd15, 6'd5);
    tick();
    vectors++; if (out_valid_a !== 1'b1 || ctrl_a !== 4'b0000 || illegal_a !== 1'b1 || busy_a !== 1'b0) begin
      miscompares++; $display("FAIL il_f5 got v=%b c=%b i=%b b=%b exp 1/0000/1/0", out_valid_a, ctrl_a, illegal_a, busy_a); end
    present(1'b0, 4'd15, 6'd28);
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid_a !== 1'b1 || ctrl_a !== 4'b0000 || illegal_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++; $display("FAIL il_aluop0 got v=%b c=%b i=%b b=%b exp 1/0000/0/0", out_valid_a, ctrl_a, illegal_a, busy_a); end
    tick();
    vectors++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++; $display("FAIL il_drain got v=%b b=%b exp 0/0", out_valid_a, busy_a); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    present(1'b1, 4'd15, 6'd28);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    present(1'b1, 4'd4, 6'd0);
    #1;
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL fl_in_ready got %b exp 0", in_ready_a); end
    tick();
    vectors++; if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
      miscompares++; $display("FAIL fl_abort got b=%b v=%b exp 0/0", busy_a, out_valid_a); end
    tick();
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL fl_idle_block got %b exp 0", out_valid_a); end
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
        miscompares++; $display("FAIL fl_no_mul k=%0d got v=%b b=%b exp 0/0", k, out_valid_a, busy_a); end
    end
    present(1'b1, 4'd6, 6'd0);
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid_a !== 1'b1 || ctrl_a !== 4'b0001) begin
      miscompares++; $display("FAIL fl_recover got v=%b c=%b exp 1/0001", out_valid_a, ctrl_a); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mid_multi_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_illegal();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
